// File: rtl/c_decr_ctr.sv
// Modulo down-counter over [min_value, max_value] with load, wraparound pulse
// and a sticky flag for out-of-range loads.
module c_decr_ctr #(
  parameter int unsigned          width       = 3,
  parameter logic [width-1:0]     min_value   = '0,
  parameter logic [width-1:0]     max_value   = {width{1'b1}},
  parameter logic [width-1:0]     reset_value = max_value
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             load,
  input  logic [width-1:0] load_value,
  input  logic             dec,
  output logic [width-1:0] count_q,
  output logic [width-1:0] count_next,
  output logic             at_min,
  output logic             wrap,
  output logic             error
);

  // Bits above the highest bit where min_value and max_value differ never change.
  function automatic logic [width-1:0] calc_const_mask(input logic [width-1:0] lo,
                                                       input logic [width-1:0] hi);
    logic [width-1:0] m;
    logic             stop;
    m    = '0;
    stop = 1'b0;
    for (int i = width - 1; i >= 0; i--) begin
      if (lo[i] != hi[i]) stop = 1'b1;
      if (!stop) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [width-1:0] const_mask = calc_const_mask(min_value, max_value);
  localparam logic [width-1:0] one        = {{(width-1){1'b0}}, 1'b1};
  // Varying field spans all-zeros..all-ones: plain subtraction wraps by itself.
  localparam bit pow2_range = ((min_value & ~const_mask) == '0) &&
                              ((max_value & ~const_mask) == ~const_mask);

  if (int'(min_value) > int'(max_value) || int'(reset_value) < int'(min_value) ||
      int'(reset_value) > int'(max_value)) begin : g_bad_params
    $error("c_decr_ctr: illegal parameters min=%0d max=%0d reset=%0d",
           min_value, max_value, reset_value);
  end

  logic [width-1:0] dec_raw;
  logic             ge_min;
  logic             le_max;
  logic             load_ok;

  assign at_min = (count_q == min_value);

  if (pow2_range) begin : g_natural_wrap
    assign dec_raw = count_q - one;
  end else begin : g_compare_wrap
    assign dec_raw = at_min ? max_value : count_q - one;
  end

  assign count_next = (max_value & const_mask) | (dec_raw & ~const_mask);

  // Range bounds that cover the whole encoding need no comparator.
  if (min_value == '0) begin : g_no_min_cmp
    assign ge_min = 1'b1;
  end else begin : g_min_cmp
    assign ge_min = (load_value >= min_value);
  end

  if (max_value == {width{1'b1}}) begin : g_no_max_cmp
    assign le_max = 1'b1;
  end else begin : g_max_cmp
    assign le_max = (load_value <= max_value);
  end

  assign load_ok = ge_min && le_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= reset_value;
      wrap    <= 1'b0;
      error   <= 1'b0;
    end else if (!active) begin
      wrap <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
      if (load_ok) begin
        count_q <= load_value;
      end else begin
        count_q <= max_value;
        error   <= 1'b1;
      end
    end else if (dec) begin
      count_q <= count_next;
      wrap    <= at_min;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_c_decr_ctr.sv
// Bench for c_decr_ctr: hand-written vector table on a [2,6] counter, plus
// model-checked runs on a power-of-two [0,7] and a single-value [5,5] counter.
module tb_c_decr_ctr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       active = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_value = 3'd0;
  logic       dec = 1'b0;

  logic [2:0] cq_a, cn_a, cq_b, cn_b, cq_c, cn_c;
  logic       am_a, wr_a, er_a, am_b, wr_b, er_b, am_c, wr_c, er_c;

  always #5 clk = ~clk;

  c_decr_ctr #(.width(3), .min_value(3'd2), .max_value(3'd6), .reset_value(3'd6)) dut_a (
    .clk(clk), .reset(reset), .active(active), .load(load), .load_value(load_value),
    .dec(dec), .count_q(cq_a), .count_next(cn_a), .at_min(am_a), .wrap(wr_a), .error(er_a));

  c_decr_ctr #(.width(3), .min_value(3'd0), .max_value(3'd7), .reset_value(3'd7)) dut_b (
    .clk(clk), .reset(reset), .active(active), .load(load), .load_value(load_value),
    .dec(dec), .count_q(cq_b), .count_next(cn_b), .at_min(am_b), .wrap(wr_b), .error(er_b));

  c_decr_ctr #(.width(3), .min_value(3'd5), .max_value(3'd5), .reset_value(3'd5)) dut_c (
    .clk(clk), .reset(reset), .active(active), .load(load), .load_value(load_value),
    .dec(dec), .count_q(cq_c), .count_next(cn_c), .at_min(am_c), .wrap(wr_c), .error(er_c));

  // Expected record: {count_q, wrap, error, at_min, count_next}
  typedef struct packed {
    logic       r;
    logic       a;
    logic       l;
    logic [2:0] lv;
    logic       d;
    logic [8:0] exp;
  } vec_t;

  vec_t       tbl[25];
  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];
  logic [8:0] exp_c[$];
  int         n_vec = 0;
  int         n_mis = 0;

  logic [2:0] m_c[3];
  logic       m_w[3];
  logic       m_e[3];
  logic [2:0] p_min[3];
  logic [2:0] p_max[3];
  logic [2:0] p_rst[3];

  function automatic logic [8:0] pack_exp(input logic [2:0] c, input logic w, input logic e,
                                          input logic [2:0] mn, input logic [2:0] mx);
    logic [2:0] nx;
    nx = (c == mn) ? mx : c - 3'd1;
    return {c, w, e, (c == mn), nx};
  endfunction

  task automatic model_step(input int k, input logic r, input logic a, input logic l,
                            input logic [2:0] lv, input logic d);
    if (r) begin
      m_c[k] = p_rst[k]; m_w[k] = 1'b0; m_e[k] = 1'b0;
    end else if (!a) begin
      m_w[k] = 1'b0;
    end else if (l) begin
      m_w[k] = 1'b0;
      if (lv >= p_min[k] && lv <= p_max[k]) m_c[k] = lv;
      else begin m_c[k] = p_max[k]; m_e[k] = 1'b1; end
    end else if (d) begin
      m_w[k] = (m_c[k] == p_min[k]);
      m_c[k] = (m_c[k] == p_min[k]) ? p_max[k] : m_c[k] - 3'd1;
    end else begin
      m_w[k] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got cnt=%0d wrap=%b err=%b at_min=%b next=%0d, expected cnt=%0d wrap=%b err=%b at_min=%b next=%0d",
               name, got[8:6], got[5], got[4], got[3], got[2:0],
               exp[8:6], exp[5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  // Drive one cycle, push expectations, then sample one time unit after the edge.
  task automatic step(input logic r, input logic a, input logic l, input logic [2:0] lv,
                      input logic d, input logic use_tbl, input logic [8:0] tbl_exp,
                      input string name);
    reset = r; active = a; load = l; load_value = lv; dec = d;
    for (int k = 0; k < 3; k++) model_step(k, r, a, l, lv, d);
    exp_a.push_back(use_tbl ? tbl_exp : pack_exp(m_c[0], m_w[0], m_e[0], p_min[0], p_max[0]));
    exp_b.push_back(pack_exp(m_c[1], m_w[1], m_e[1], p_min[1], p_max[1]));
    exp_c.push_back(pack_exp(m_c[2], m_w[2], m_e[2], p_min[2], p_max[2]));
    @(posedge clk);
    #1;
    check({name, "_a"}, {cq_a, wr_a, er_a, am_a, cn_a}, exp_a.pop_front());
    check({name, "_b"}, {cq_b, wr_b, er_b, am_b, cn_b}, exp_b.pop_front());
    check({name, "_c"}, {cq_c, wr_c, er_c, am_c, cn_c}, exp_c.pop_front());
  endtask

  task automatic set_vec(input int i, input logic r, input logic a, input logic l,
                         input logic [2:0] lv, input logic d, input logic [2:0] c,
                         input logic w, input logic e, input logic am, input logic [2:0] nx);
    tbl[i] = '{r: r, a: a, l: l, lv: lv, d: d, exp: {c, w, e, am, nx}};
  endtask

  initial begin
    p_min[0] = 3'd2; p_max[0] = 3'd6; p_rst[0] = 3'd6;
    p_min[1] = 3'd0; p_max[1] = 3'd7; p_rst[1] = 3'd7;
    p_min[2] = 3'd5; p_max[2] = 3'd5; p_rst[2] = 3'd5;
    for (int k = 0; k < 3; k++) begin
      m_c[k] = 3'd0; m_w[k] = 1'b0; m_e[k] = 1'b0;
    end

    //          r  a  l  lv d   cnt w  e  am nxt
    set_vec( 0, 1, 0, 1, 3, 1,  6, 0, 0, 0, 5);
    set_vec( 1, 0, 1, 0, 0, 1,  5, 0, 0, 0, 4);
    set_vec( 2, 0, 1, 0, 0, 1,  4, 0, 0, 0, 3);
    set_vec( 3, 0, 1, 0, 0, 1,  3, 0, 0, 0, 2);
    set_vec( 4, 0, 1, 0, 0, 1,  2, 0, 0, 1, 6);
    set_vec( 5, 0, 1, 0, 0, 1,  6, 1, 0, 0, 5);
    set_vec( 6, 0, 1, 0, 0, 0,  6, 0, 0, 0, 5);
    set_vec( 7, 0, 1, 1, 4, 1,  4, 0, 0, 0, 3);
    set_vec( 8, 0, 1, 0, 0, 1,  3, 0, 0, 0, 2);
    set_vec( 9, 0, 1, 1, 7, 0,  6, 0, 1, 0, 5);
    set_vec(10, 0, 1, 1, 3, 0,  3, 0, 1, 0, 2);
    set_vec(11, 0, 1, 1, 1, 0,  6, 0, 1, 0, 5);
    set_vec(12, 0, 0, 1, 2, 1,  6, 0, 1, 0, 5);
    set_vec(13, 0, 0, 1, 2, 1,  6, 0, 1, 0, 5);
    set_vec(14, 0, 0, 1, 2, 1,  6, 0, 1, 0, 5);
    set_vec(15, 0, 1, 0, 0, 1,  5, 0, 1, 0, 4);
    set_vec(16, 1, 1, 0, 0, 1,  6, 0, 0, 0, 5);
    set_vec(17, 0, 1, 1, 2, 0,  2, 0, 0, 1, 6);
    set_vec(18, 0, 0, 0, 0, 1,  2, 0, 0, 1, 6);
    set_vec(19, 0, 1, 0, 0, 1,  6, 1, 0, 0, 5);
    set_vec(20, 0, 1, 0, 0, 1,  5, 0, 0, 0, 4);
    set_vec(21, 0, 1, 0, 0, 1,  4, 0, 0, 0, 3);
    set_vec(22, 0, 1, 0, 0, 1,  3, 0, 0, 0, 2);
    set_vec(23, 1, 1, 0, 0, 1,  6, 0, 0, 0, 5);
    set_vec(24, 0, 1, 0, 0, 1,  5, 0, 0, 0, 4);

    #1;
    for (int i = 0; i < 25; i++)
      step(tbl[i].r, tbl[i].a, tbl[i].l, tbl[i].lv, tbl[i].d, 1'b1, tbl[i].exp, $sformatf("tbl%0d", i));

    // Every count value loaded, then a full decrement lap to exercise wraparound.
    step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 9'd0, "rst2");
    for (int v = 0; v < 8; v++)
      step(1'b0, 1'b1, 1'b1, 3'(v), 1'b0, 1'b0, 9'd0, $sformatf("ld%0d", v));
    step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 9'd0, "ld0b");
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 9'd0, $sformatf("lap%0d", i));

    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0, 1'b0, 9'd0, $sformatf("rnd%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
